// File: rtl/tx_retry_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_retry_fifo
// Brief    : Transmit byte buffer with commit/rewind pointers so that an
//            un-acknowledged packet can be resent without refilling.
// Revision : 1.0 - initial release
// ============================================================================
module tx_retry_fifo #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    input  logic                       w_enable,
    input  logic [DATA_WIDTH-1:0]      w_data,
    input  logic                       r_enable,
    output logic [DATA_WIDTH-1:0]      r_data,
    input  logic                       packet_ack,
    input  logic                       packet_nak,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] c_DEPTH_PTR = PW'(DEPTH);
    localparam logic [PW-1:0] c_PTR_ONE   = PW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_base_ptr;

    logic [PW-1:0] w_occupancy;
    logic [PW-1:0] w_pending;
    logic          w_empty;
    logic          w_full;
    logic          w_do_write;
    logic          w_do_read;
    logic          w_do_ack;
    logic          w_do_nak;

    always_comb begin
        w_occupancy = r_wr_ptr - r_base_ptr;
        w_pending   = r_wr_ptr - r_rd_ptr;
        w_empty     = (r_wr_ptr == r_rd_ptr);
        w_full      = (w_occupancy == c_DEPTH_PTR);
        w_do_ack    = packet_ack;
        w_do_nak    = packet_nak && !packet_ack;
        w_do_write  = w_enable && !w_full && n_rst && !clear;
        // A rewind overrides a concurrent read; ack does not.
        w_do_read   = r_enable && !w_empty && !w_do_nak;
    end

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_base_ptr <= '0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_ack) begin
                r_base_ptr <= r_rd_ptr;
            end
            if (w_do_nak) begin
                r_rd_ptr <= r_base_ptr;
            end else if (w_do_read) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage carries no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_data;
        end
    end

    assign r_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign empty     = w_empty;
    assign full      = w_full;
    assign occupancy = w_occupancy;
    assign pending   = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_tx_retry_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_retry_fifo
// Brief    : Directed vector bench for tx_retry_fifo (DEPTH=64, 8-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_retry_fifo;

    logic       clk = 1'b0;
    logic       n_rst, clear, w_enable, r_enable, packet_ack, packet_nak;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty, full;
    logic [6:0] occupancy, pending;

    int checks = 0;
    int errors = 0;

    tx_retry_fifo #(.DEPTH(64), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .w_enable   (w_enable),
        .w_data     (w_data),
        .r_enable   (r_enable),
        .r_data     (r_data),
        .packet_ack (packet_ack),
        .packet_nak (packet_nak),
        .empty      (empty),
        .full       (full),
        .occupancy  (occupancy),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       ack;
        logic       nak;
        logic       e_empty;
        logic       e_full;
        logic [6:0] e_occ;
        logic [6:0] e_pend;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic re,
                                input logic ack, input logic nak, input logic e_empty,
                                input logic [6:0] e_occ, input logic [6:0] e_pend,
                                input logic [7:0] e_rd);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.ack = ack; v.nak = nak;
        v.e_empty = e_empty; v.e_full = 1'b0;
        v.e_occ = e_occ; v.e_pend = e_pend; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_empty, input logic e_full,
                           input int e_occ, input int e_pend, input int e_rd);
        chk({tag, " empty"},     int'(empty),     int'(e_empty));
        chk({tag, " full"},      int'(full),      int'(e_full));
        chk({tag, " occupancy"}, int'(occupancy), e_occ);
        chk({tag, " pending"},   int'(pending),   e_pend);
        chk({tag, " r_data"},    int'(r_data),    e_rd);
    endtask

    // Drive one cycle of inputs, clock it, and return 1 time unit after the edge.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                       input logic ack, input logic nak, input logic clr);
        w_enable = we; w_data = wd; r_enable = re;
        packet_ack = ack; packet_nak = nak; clear = clr;
        @(posedge clk);
        #1;
        w_enable = 1'b0; r_enable = 1'b0; packet_ack = 1'b0;
        packet_nak = 1'b0; clear = 1'b0; w_data = 8'h00;
    endtask

    initial begin
        n_rst = 1'b0; clear = 1'b0; w_enable = 1'b0; w_data = 8'h00;
        r_enable = 1'b0; packet_ack = 1'b0; packet_nak = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 1'b1, 1'b0, 0, 0, 0);
        n_rst = 1'b1;

        // Fill to full, then attempt an overflow write.
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 62) chk("fill full@63", int'(full), 0);
        end
        chk_all("fill64", 1'b0, 1'b1, 64, 64, 0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("overflow", 1'b0, 1'b1, 64, 64, 0);

        // Read 10 bytes; space is only released on ack.
        for (int i = 0; i < 10; i++) begin
            chk("read10 r_data", int'(r_data), i);
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk_all("read10", 1'b0, 1'b1, 64, 54, 10);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("ack10", 1'b0, 1'b0, 54, 54, 10);

        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("clear1", 1'b1, 1'b0, 0, 0, 0);

        // Vector table: inputs for one cycle and the outputs expected after the edge.
        vt.push_back(mk(1, 8'h11, 0, 0, 0, 0, 1, 1, 8'h11));
        vt.push_back(mk(1, 8'h22, 0, 0, 0, 0, 2, 2, 8'h11));
        vt.push_back(mk(1, 8'h33, 0, 0, 0, 0, 3, 3, 8'h11));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 3, 2, 8'h22));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 3, 1, 8'h33));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 3, 0, 8'h00));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 3, 0, 8'h00)); // read while empty
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 3, 3, 8'h11)); // nak rewinds
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 3, 2, 8'h22));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 3, 1, 8'h33));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 3, 0, 8'h00));
        vt.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00)); // ack releases
        for (int k = 0; k < 8; k++)
            vt.push_back(mk(1, 8'h41 + 8'(k), 0, 0, 0, 0, 7'(k + 1), 7'(k + 1), 8'h41));
        for (int k = 0; k < 5; k++)
            vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8, 7'(7 - k), 8'h42 + 8'(k)));
        vt.push_back(mk(0, 8'h00, 0, 1, 1, 0, 3, 3, 8'h46)); // ack+nak: ack wins
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 3, 2, 8'h47));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 3, 3, 8'h46)); // nak+read: no increment
        vt.push_back(mk(0, 8'h00, 1, 1, 0, 0, 3, 2, 8'h47)); // read+ack: base=old rd
        vt.push_back(mk(1, 8'h49, 0, 0, 1, 0, 4, 4, 8'h46)); // write+nak
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 4, 3, 8'h47));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 4, 2, 8'h48));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 4, 1, 8'h49));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 4, 0, 8'h00));
        vt.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00));
        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].we, vt[i].wd, vt[i].re, vt[i].ack, vt[i].nak, 1'b0);
            chk_all($sformatf("vec%0d", i), vt[i].e_empty, vt[i].e_full,
                    int'(vt[i].e_occ), int'(vt[i].e_pend), int'(vt[i].e_rd));
        end

        // Stream 200 bytes in packets of 16 across both index and pointer wrap.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        begin
            int n = 0;
            while (n < 200) begin
                int blk = (200 - n < 16) ? (200 - n) : 16;
                for (int k = 0; k < blk; k++)
                    cyc(1'b1, 8'((n + k) * 7 + 3), 1'b0, 1'b0, 1'b0, 1'b0);
                chk("stream pending", int'(pending), blk);
                for (int k = 0; k < blk; k++) begin
                    chk("stream r_data", int'(r_data), ((n + k) * 7 + 3) & 255);
                    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
                end
                cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
                chk_all("stream ack", 1'b1, 1'b0, 0, 0, 0);
                n += blk;
            end
        end
        // Pointers now sit at 72; filling 64 crosses the 127->0 pointer wrap.
        for (int k = 0; k < 64; k++)
            cyc(1'b1, 8'(k ^ 8'h5A), 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("wrapfull", 1'b0, 1'b1, 64, 64, 8'h5A);
        for (int k = 0; k < 64; k++) begin
            chk("wrap r_data", int'(r_data), k ^ 8'h5A);
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk_all("wrapdrain", 1'b1, 1'b1, 64, 0, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("wrapack", 1'b1, 1'b0, 0, 0, 0);

        // Clear mid-packet, with competing inputs that clear must override.
        for (int k = 0; k < 12; k++)
            cyc(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("preclear", 1'b0, 1'b0, 12, 7, 8'hC5);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_all("clear2", 1'b1, 1'b0, 0, 0, 0);

        // Reset during a write discards the write.
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 8'(8'h70 + k), 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("prerst", 1'b0, 1'b0, 3, 3, 8'h70);
        n_rst = 1'b0;
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("rstwrite", 1'b1, 1'b0, 0, 0, 0);
        n_rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("postrst", 1'b1, 1'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
